// File: rtl/lsu_align.sv
// Load/store alignment sequencer: aligned accesses pass through as one memory beat; misaligned
// half/word accesses are split into byte beats when LSU_MISALIGN_SPLIT_EN is defined, else flagged.
module lsu_align #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_wdata_i,
   input  logic [2:0]        req_funct3_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DWIDTH-1:0] resp_rdata_o,
   output logic              misalign_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   output logic [2:0]        mem_funct3_o,
   input  logic [DWIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_reg, state_next;
   logic              we_reg;
   logic [AWIDTH-1:0] addr_reg;
   logic [DWIDTH-1:0] wdata_reg;
   logic [2:0]        funct3_reg;
   logic [DWIDTH-1:0] asm_reg, asm_next;

   logic is_byte, is_half, aligned;

   assign is_byte = (funct3_reg[1:0] == 2'd0);
   assign is_half = (funct3_reg[1:0] == 2'd1);
   assign aligned = is_byte || (is_half && !addr_reg[0]) ||
                    (!is_byte && !is_half && (addr_reg[1:0] == 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [1:0] beat_reg, beat_next;
   logic       last_beat;

   assign last_beat = is_half ? (beat_reg == 2'd1) : (beat_reg == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) beat_reg <= 2'd0;
      else      beat_reg <= beat_next;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         asm_reg    <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         funct3_reg <= 3'd0;
      end else begin
         state_reg <= state_next;
         asm_reg   <= asm_next;
         if (state_reg == IDLE && req_valid_i) begin
            we_reg     <= req_we_i;
            addr_reg   <= req_addr_i;
            wdata_reg  <= req_wdata_i;
            funct3_reg <= req_funct3_i;
         end
      end
   end

   // Outputs are decoded from state alone so an asynchronous reset clears them immediately.
   always_comb begin
      state_next     = state_reg;
      asm_next       = asm_reg;
      req_ready_o    = 1'b0;
      resp_valid_o   = 1'b0;
      resp_rdata_o   = '0;
      misalign_o     = 1'b0;
      mem_addr_o     = '0;
      mem_data_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_funct3_o   = 3'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat_next      = beat_reg;
`endif
      case (state_reg)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_next = ACCESS;
               asm_next   = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
               beat_next  = 2'd0;
`endif
            end
         end
         ACCESS: begin
            if (aligned) begin
               mem_addr_o     = addr_reg;
               mem_data_o     = wdata_reg;
               mem_funct3_o   = funct3_reg;
               mem_read_en_o  = !we_reg;
               mem_write_en_o = we_reg;
               if (!we_reg) asm_next = mem_rdata_i;
               state_next = RESP;
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
               mem_addr_o     = addr_reg + AWIDTH'(beat_reg);
               mem_data_o     = {{(DWIDTH-8){1'b0}}, wdata_reg[{beat_reg, 3'b000} +: 8]};
               mem_funct3_o   = we_reg ? 3'b000 : 3'b100;
               mem_read_en_o  = !we_reg;
               mem_write_en_o = we_reg;
               if (!we_reg) asm_next[{beat_reg, 3'b000} +: 8] = mem_rdata_i[7:0];
               beat_next = beat_reg + 2'd1;
               if (last_beat) begin
                  // Stores leave the assembly register at zero, so extension is harmless there.
                  if (is_half)
                     asm_next[DWIDTH-1:16] = {(DWIDTH-16){!funct3_reg[2] && asm_next[15]}};
                  state_next = RESP;
               end
`else
               misalign_o = 1'b1;
               state_next = RESP;
`endif
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_rdata_o = asm_reg;
            if (resp_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_align.sv
// Table-driven bench for lsu_align with a byte-addressable memory model; expectations follow
// whichever build is compiled (LSU_MISALIGN_SPLIT_EN defined or not).
module tb_lsu_align;

   localparam logic [31:0] B = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = 3'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   lsu_align #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .req_funct3_i   (req_funct3),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_rdata_o   (resp_rdata),
      .misalign_o     (misalign),
      .mem_addr_o     (mem_addr),
      .mem_data_o     (mem_data),
      .mem_read_en_o  (mem_read_en),
      .mem_write_en_o (mem_write_en),
      .mem_funct3_o   (mem_funct3),
      .mem_rdata_i    (mem_rdata)
   );

   // Little-endian byte memory, 256 bytes indexed by the low address byte.
   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic [7:0] a0, a1, a2, a3;
   assign a0 = mem_addr[7:0];
   assign a1 = a0 + 8'd1;
   assign a2 = a0 + 8'd2;
   assign a3 = a0 + 8'd3;

   always_comb begin
      case (mem_funct3)
         3'd0:    mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
         3'd4:    mem_rdata = {24'd0, mem[a0]};
         3'd1:    mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
         3'd5:    mem_rdata = {16'd0, mem[a1], mem[a0]};
         default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_write_en) begin
         mem[a0] <= mem_data[7:0];
         if (mem_funct3[1:0] != 2'd0) mem[a1] <= mem_data[15:8];
         if (mem_funct3[1:0] >= 2'd2) begin
            mem[a2] <= mem_data[23:16];
            mem[a3] <= mem_data[31:24];
         end
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          mis_beats;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_beats;
      int          exp_mis;
      int          hold;
      logic        early;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // mis_beats: 0 = aligned access, 2/4 = misaligned half/word (beat count when split).
   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [2:0] f3, input int mis_beats,
                               input logic [31:0] rd_split, input logic [31:0] rd_off,
                               input int hold, input logic early);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wd; v.f3 = f3; v.mis_beats = mis_beats;
      v.hold = hold; v.early = early;
`ifdef LSU_MISALIGN_SPLIT_EN
      v.exp_rdata = rd_split;
      v.exp_lat   = (mis_beats == 0) ? 2 : mis_beats + 1;
      v.exp_beats = (mis_beats == 0) ? 1 : mis_beats;
      v.exp_mis   = 0;
`else
      v.exp_rdata = rd_off;
      v.exp_lat   = 2;
      v.exp_beats = (mis_beats == 0) ? 1 : 0;
      v.exp_mis   = (mis_beats == 0) ? 0 : 1;
`endif
      return v;
   endfunction

   task automatic run(input vec_t v);
      int cyc;
      int beats;
      int mis_cnt;
      int mis_cyc;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
      req_wdata = v.wdata; req_funct3 = v.f3; resp_ready = v.early;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1; beats = 0; mis_cnt = 0; mis_cyc = 0;
      while (!resp_valid && cyc <= 20) begin
         chk("req_ready_busy", req_ready, 0);
         if (mem_read_en || mem_write_en) begin
            chk("beat_we", mem_write_en, v.we);
            chk("beat_re", mem_read_en, !v.we);
            if (v.mis_beats == 0) begin
               chk("beat_addr", mem_addr, v.addr);
               chk("beat_f3", 32'(mem_funct3), 32'(v.f3));
               chk("beat_data", mem_data, v.wdata);
            end else begin
               chk("beat_addr", mem_addr, v.addr + 32'(beats));
               chk("beat_f3", 32'(mem_funct3), v.we ? 32'd0 : 32'd4);
               if (v.we) chk("beat_data", mem_data, (v.wdata >> (8 * beats)) & 32'hFF);
            end
            beats++;
         end
         if (misalign) begin
            mis_cnt++;
            mis_cyc = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("resp_latency", 32'(cyc), 32'(v.exp_lat));
      chk("resp_rdata", resp_rdata, v.exp_rdata);
      chk("mem_beats", 32'(beats), 32'(v.exp_beats));
      chk("misalign_pulses", 32'(mis_cnt), 32'(v.exp_mis));
      if (v.exp_mis != 0) chk("misalign_cycle", 32'(mis_cyc), 1);
      if (v.early) begin
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end else begin
         for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, v.exp_rdata);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_mem_en", {mem_read_en, mem_write_en}, 0);
         end
         @(negedge clk);
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end
      chk("resp_done", resp_valid, 0);
      chk("req_ready_back", req_ready, 1);
      $display("[TB] txn we=%0d addr=%h f3=%0d rdata=%h lat=%0d beats=%0d mis=%0d",
               v.we, v.addr, v.f3, v.exp_rdata, cyc, beats, mis_cnt);
   endtask

   task automatic chk_outputs_cleared(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_misalign"}, misalign, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_data"}, mem_data, 0);
      chk({tag, "_mem_en"}, {mem_read_en, mem_write_en}, 0);
      chk({tag, "_mem_f3"}, 32'(mem_funct3), 0);
   endtask

   initial begin
      vecs.push_back(mk(1, B,           32'hDEADBEEF, 3'd2, 0, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, B,           32'h0,        3'd2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0));
      vecs.push_back(mk(1, B + 32'h01,  32'h34,       3'd0, 0, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(1, B + 32'h02,  32'h82,       3'd0, 0, 32'h0,        32'h0,        0, 1));
      vecs.push_back(mk(0, B + 32'h01,  32'h0,        3'd1, 2, 32'hFFFF8234, 32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h01,  32'h0,        3'd5, 2, 32'h00008234, 32'h0,        2, 0));
      vecs.push_back(mk(0, B + 32'h02,  32'h0,        3'd0, 0, 32'hFFFFFF82, 32'hFFFFFF82, 0, 0));
      vecs.push_back(mk(0, B + 32'h02,  32'h0,        3'd4, 0, 32'h00000082, 32'h00000082, 0, 0));
      vecs.push_back(mk(0, B + 32'h02,  32'h0,        3'd1, 0, 32'hFFFFDE82, 32'hFFFFDE82, 0, 0));
      vecs.push_back(mk(0, B + 32'h02,  32'h0,        3'd5, 0, 32'h0000DE82, 32'h0000DE82, 0, 1));
      vecs.push_back(mk(1, B + 32'h23,  32'hA1B2C3D4, 3'd2, 4, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h24,  32'h0,        3'd2, 0, 32'h00A1B2C3, 32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h22,  32'h0,        3'd7, 4, 32'hB2C3D400, 32'h0,        0, 1));
      vecs.push_back(mk(1, B + 32'h31,  32'h5678BEEF, 3'd1, 2, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h31,  32'h0,        3'd5, 2, 32'h0000BEEF, 32'h0,        0, 0));
      vecs.push_back(mk(1, B + 32'h32,  32'h00001234, 3'd1, 0, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h30,  32'h0,        3'd2, 0, 32'h1234EF00, 32'h12340000, 0, 0));
      vecs.push_back(mk(0, 32'hFFFFFFFF, 32'h0,       3'd1, 2, 32'hFFFFEF00, 32'h0,        0, 0));
      vecs.push_back(mk(0, B + 32'h03,  32'h0,        3'd2, 4, 32'h000000DE, 32'h0,        1, 0));

      #3;
      chk_outputs_cleared("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run(vecs[i]);

      // Reset during the third beat of a misaligned word store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = B + 32'h43;
      req_wdata = 32'hA1B2C3D4; req_funct3 = 3'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
`ifdef LSU_MISALIGN_SPLIT_EN
      chk("midop_beat2_addr", mem_addr, B + 32'h45);
      chk("midop_beat2_we", mem_write_en, 1);
`else
      chk("midop_resp_valid", resp_valid, 1);
`endif
      rst = 1'b0;
      #1;
      chk_outputs_cleared("midop");
      @(negedge clk);
      rst = 1'b1;
      $display("[TB] txn reset asserted during misaligned SW to %h", B + 32'h43);
      run(mk(0, B + 32'h44, 32'h0, 3'd2, 0, 32'h000000C3, 32'h0, 0, 0));
      run(mk(0, B + 32'h43, 32'h0, 3'd4, 0, 32'h000000D4, 32'h0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment sequencer between the execute/memory pipeline stage and the byte-addressable data `memory` block. It accepts one load or store request at a time over a valid/ready handshake. Naturally aligned accesses go to memory as a single access. Misaligned halfword/word accesses are split into sequential byte beats, and the load result is reassembled and sign- or zero-extended before return.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width; only 32 is supported
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`
- `req_we_i`  in  1  1 = store, 0 = load
- `req_addr_i`  in  AWIDTH  byte address
- `req_wdata_i`  in  DWIDTH  store data, right-aligned
- `req_funct3_i`  in  3  RISC-V load/store funct3
- `resp_valid_o`  out  1  response valid (loads and stores)
- `resp_ready_i`  in  1  response consumed
- `resp_rdata_o`  out  DWIDTH  extended load result; 0 for stores
- `misalign_o`  out  1  one-cycle pulse: misaligned request rejected (macro off only)
- `mem_addr_o`  out  AWIDTH  to memory `addr_i`
- `mem_data_o`  out  DWIDTH  to memory `data_i`
- `mem_read_en_o`  out  1  to memory `read_en_i`
- `mem_write_en_o`  out  1  to memory `write_en_i`
- `mem_funct3_o`  out  3  to memory `funct3_i`
- `mem_rdata_i`  in  DWIDTH  from memory `data_o`; combinational read

## Operation
- Size comes from `funct3[1:0]`:
  - 0 = byte.
  - 1 = half.
  - 2 or 3 = word. Encodings 3 and 7 are treated as word.
- Load sign: `funct3[2]` = 0 means sign-extend; 1 means zero-extend.
- Aligned means any of:
  - byte access;
  - half access with `addr[0]` = 0;
  - word access with `addr[1:0]` = 0.
- States:
  - IDLE: `req_ready_o` = 1. On handshake, latch we/addr/wdata/funct3, clear the beat counter and the assembly register, and go to ACCESS.
  - ACCESS, aligned: one beat. Drive latched addr, wdata and funct3 unchanged. Assert `mem_read_en_o` (load) or `mem_write_en_o` (store). For loads, capture `mem_rdata_i` as the final result. Go to RESP.
  - ACCESS, misaligned: N beats, where N = 2 (half) or 4 (word).
    - Beat k drives address `addr+k`, modulo 2^AWIDTH.
    - Beat k funct3 is 3'b100 (LBU) for loads and 3'b000 (SB) for stores.
    - Store data for beat k is `{24'b0, wdata[8k+7:8k]}`.
    - Loads write `mem_rdata_i[7:0]` into assembly bits `[8k+7:8k]`.
    - After beat N-1, apply extension from bit 15 (half) and go to RESP.
  - RESP: `resp_valid_o` = 1 and `resp_rdata_o` held stable. On `resp_ready_i`, go to IDLE.
- Memory enables are 0 in every state except ACCESS. Memory outputs are 0 in IDLE and RESP.
- Reset mid-operation aborts the transaction immediately. Store bytes already written stay in memory; there is no rollback.

## Timing
- Reset values:
  - state IDLE, so `req_ready_o` = 1;
  - `resp_valid_o`, `resp_rdata_o`, `misalign_o` = 0;
  - all `mem_*` outputs = 0.
- With handshake at cycle T:
  - aligned access in T+1, `resp_valid_o` in T+2;
  - misaligned half: beats T+1..T+2, response T+3;
  - misaligned word: beats T+1..T+4, response T+5.
- `req_ready_o` is 0 from T+1 until the cycle after the response handshake. No request overlap is possible.
- If `resp_ready_i` is already high when `resp_valid_o` rises, the response completes in that cycle and `req_ready_o` returns at the next cycle.
- Throughput: at most one request per 3 cycles (aligned).

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned accesses are split as described above.
- `LSU_MISALIGN_SPLIT_EN` undefined: a misaligned request is still accepted, but no memory enable is asserted.
  - `misalign_o` pulses in T+1.
  - The block then enters RESP with `resp_rdata_o` = 0.
  - Aligned behaviour is identical in both builds.

## Test plan
- Aligned load: memory word 0xDEADBEEF at 0x01000000; LW to 0x01000000 accepted at T -> `resp_rdata_o` = 0xDEADBEEF with `resp_valid_o` at T+2; exactly one read-enable cycle.
- Misaligned halves: mem[0x01000001] = 0x34 and mem[0x01000002] = 0x82.
  - LH to 0x01000001 -> 0xFFFF8234 at T+3.
  - LHU to 0x01000001 -> 0x00008234 at T+3.
- Misaligned store: SW 0xA1B2C3D4 to 0x01000003 -> four SB beats.
  - Addresses 0x01000003..06, data 0xD4, 0xC3, 0xB2, 0xA1.
  - Response at T+5; a following LW of 0x01000004 returns 0x00A1B2C3 from an initially zero memory.
- Backpressure: `resp_ready_i` held low for 3 cycles after response -> `resp_valid_o` and `resp_rdata_o` stable; `req_ready_o` stays 0; no memory enables.
- Reset mid-op: `rst` asserted low during beat 2 of the misaligned SW above -> all outputs 0 combinationally; only bytes 0x01000003 and 0x01000004 modified.
- Macro off: LW to 0x01000002 -> `misalign_o` pulses at T+1; no memory enables; `resp_rdata_o` = 0 at T+2.
